// File: rtl/packetizer_ta_arb_if.sv
// Requester, packetizer and response-return signals of the round-robin tag arbiter.
// The arbiter binds to the slave modport; the requester/packetizer side binds to master.
interface packetizer_ta_arb_if #(
  parameter int NUM_REQ          = 4,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_TAG        = 8
) ();

  logic [NUM_REQ*WIDTH_IN-1:0]         req_data_in;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0]    req_dst_in;
  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0] req_vc_in;
  logic [NUM_REQ-1:0]                  req_valid_in;
  logic [NUM_REQ-1:0]                  req_ready_out;

  logic [WIDTH_IN-1:0]                 pk_data_out;
  logic [ADDRESS_WIDTH-1:0]            pk_dst_out;
  logic [VC_ADDRESS_WIDTH-1:0]         pk_vc_out;
  logic [WIDTH_TAG-1:0]                pk_tag_out;
  logic                                pk_valid_out;
  logic                                pk_ready_in;

  logic                                ret_valid_in;
  logic [WIDTH_TAG-1:0]                ret_tag_in;
  logic                                err_underflow;

  modport slave (
    input  req_data_in, req_dst_in, req_vc_in, req_valid_in,
    input  pk_ready_in, ret_valid_in, ret_tag_in,
    output req_ready_out,
    output pk_data_out, pk_dst_out, pk_vc_out, pk_tag_out, pk_valid_out,
    output err_underflow
  );

  modport master (
    output req_data_in, req_dst_in, req_vc_in, req_valid_in,
    output pk_ready_in, ret_valid_in, ret_tag_in,
    input  req_ready_out,
    input  pk_data_out, pk_dst_out, pk_vc_out, pk_tag_out, pk_valid_out,
    input  err_underflow
  );

endinterface

// File: rtl/packetizer_ta_arb.sv
// Round-robin arbiter and tag scheduler feeding one tag-appending packetizer.
// Tags are {per-requester sequence, requester id}; per-requester credits return via ret_tag_in.
module packetizer_ta_arb #(
  parameter int NUM_REQ          = 4,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_TAG        = 8,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic               clk,
  input  logic               rst,
  packetizer_ta_arb_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SEQ_W = WIDTH_TAG - ID_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [SEQ_W-1:0] seq_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [WIDTH_IN-1:0]         data;
    logic [ADDRESS_WIDTH-1:0]    dst;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
    logic [WIDTH_TAG-1:0]        tag;
  } word_t;

  // Architectural state
  word_t        out_q;
  logic         out_valid_q;
  cnt_t         outstanding_q [NUM_REQ];
  seq_t         seq_q         [NUM_REQ];
  id_t          last_grant_q;
  logic         err_q;

  // Combinational decisions
  logic               loadable;
  logic               load;
  logic               grant_found;
  id_t                grant_id;
  id_t                ret_id;
  logic               underflow_hit;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;
  word_t              load_word;

  // The holding register can take a new word when empty or when its word leaves this cycle.
  assign loadable = !out_valid_q || bus.pk_ready_in;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid_in[i] && (outstanding_q[i] < cnt_t'(MAX_OUTSTANDING));
    end
  end

  // Search from last_grant+1; the id-width truncation supplies the modulo-NUM_REQ wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!grant_found && eligible[id_t'(int'(last_grant_q) + off)]) begin
        grant_found = 1'b1;
        grant_id    = id_t'(int'(last_grant_q) + off);
      end
    end
  end

  // No accept is offered while reset is asserted, so nothing is consumed on a reset edge.
  always_comb begin
    grant_onehot = '0;
    if (!rst && loadable && grant_found) begin
      grant_onehot[grant_id] = 1'b1;
    end
  end

  assign bus.req_ready_out = grant_onehot;
  assign load              = |(bus.req_valid_in & grant_onehot);

  always_comb begin
    load_word      = '0;
    load_word.data = bus.req_data_in[int'(grant_id)*WIDTH_IN +: WIDTH_IN];
    load_word.dst  = bus.req_dst_in[int'(grant_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    load_word.vc   = bus.req_vc_in[int'(grant_id)*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
    load_word.tag  = {seq_q[grant_id], grant_id};
  end

  // Only the id field of a returned tag matters for credit accounting.
  assign ret_id        = bus.ret_tag_in[ID_W-1:0];
  assign underflow_hit = bus.ret_valid_in && (outstanding_q[ret_id] == '0);

  logic unused_ret_seq;
  assign unused_ret_seq = ^bus.ret_tag_in[WIDTH_TAG-1:ID_W];

  // A return against an empty counter is flagged and otherwise ignored.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i] = load && (grant_id == id_t'(i));
      dec[i] = bus.ret_valid_in && (ret_id == id_t'(i)) && (outstanding_q[i] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the counter and sequence arrays are small flop banks holding live credit state, not
  // RAM, so they are reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= id_t'(NUM_REQ - 1);
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outstanding_q[i] <= '0;
        seq_q[i]         <= '0;
      end
    end else begin
      if (load) begin
        out_q                  <= load_word;
        out_valid_q            <= 1'b1;
        last_grant_q           <= grant_id;
        seq_q[grant_id]        <= seq_q[grant_id] + 1'b1;
      end else if (out_valid_q && bus.pk_ready_in) begin
        out_valid_q <= 1'b0;
      end

      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i]) begin
          outstanding_q[i] <= outstanding_q[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          outstanding_q[i] <= outstanding_q[i] - 1'b1;
        end
      end

      if (underflow_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.pk_data_out   = out_q.data;
  assign bus.pk_dst_out    = out_q.dst;
  assign bus.pk_vc_out     = out_q.vc;
  assign bus.pk_tag_out    = out_q.tag;
  assign bus.pk_valid_out  = out_valid_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_packetizer_ta_arb.sv
// Bench for packetizer_ta_arb: a negedge monitor runs a reference arbiter/credit model and a
// scoreboard of expected packetizer words; scenario tasks add targeted constant checks.
module tb_packetizer_ta_arb;

  localparam int NUM_REQ          = 4;
  localparam int ADDRESS_WIDTH    = 4;
  localparam int VC_ADDRESS_WIDTH = 1;
  localparam int WIDTH_IN         = 12;
  localparam int WIDTH_TAG        = 8;
  localparam int MAX_OUTSTANDING  = 4;
  localparam int ID_W             = 2;

  typedef struct packed {
    logic [WIDTH_IN-1:0]         data;
    logic [ADDRESS_WIDTH-1:0]    dst;
    logic [VC_ADDRESS_WIDTH-1:0] vc;
    logic [WIDTH_TAG-1:0]        tag;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  packetizer_ta_arb_if #(
    .NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(ADDRESS_WIDTH), .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
    .WIDTH_IN(WIDTH_IN), .WIDTH_TAG(WIDTH_TAG)
  ) bus ();

  packetizer_ta_arb #(
    .NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(ADDRESS_WIDTH), .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
    .WIDTH_IN(WIDTH_IN), .WIDTH_TAG(WIDTH_TAG), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, as of the most recent rising edge
  bit         mon_en = 1'b0;
  bit         m_valid;
  int         m_last;
  int         m_out [NUM_REQ];
  logic [5:0] m_seq [NUM_REQ];
  bit         m_err;
  pkt_t       exp_q [$];
  int         grant_log [$];
  logic [7:0] tag_log [$];

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] exp_ready;
    int   g;
    int   r;
    pkt_t p;
    if (rst) begin
      m_valid = 1'b0;
      m_last  = NUM_REQ - 1;
      m_err   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        m_out[i] = 0;
        m_seq[i] = '0;
      end
      exp_q.delete();
      mon_en = 1'b1;
    end else if (mon_en) begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) elig[i] = bus.req_valid_in[i] && (m_out[i] < MAX_OUTSTANDING);
      exp_ready = '0;
      g = -1;
      if (!m_valid || bus.pk_ready_in) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (g < 0 && elig[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;

      tests_run++;
      if (bus.req_ready_out !== exp_ready) begin
        tests_failed++;
        $display("FAIL mon_req_ready: got %b expected %b at %0t", bus.req_ready_out, exp_ready, $time);
      end
      tests_run++;
      if (bus.pk_valid_out !== m_valid) begin
        tests_failed++;
        $display("FAIL mon_pk_valid: got %b expected %b at %0t", bus.pk_valid_out, m_valid, $time);
      end
      tests_run++;
      if (bus.err_underflow !== m_err) begin
        tests_failed++;
        $display("FAIL mon_err_underflow: got %b expected %b at %0t", bus.err_underflow, m_err, $time);
      end

      if (m_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL mon_scoreboard_empty: got pk_valid_out=1 expected no word at %0t", $time);
        end else begin
          p = exp_q[0];
          if ({bus.pk_data_out, bus.pk_dst_out, bus.pk_vc_out, bus.pk_tag_out} !== p) begin
            tests_failed++;
            $display("FAIL mon_pk_word: got %h/%h/%h/%h expected %h/%h/%h/%h at %0t",
                     bus.pk_data_out, bus.pk_dst_out, bus.pk_vc_out, bus.pk_tag_out,
                     p.data, p.dst, p.vc, p.tag, $time);
          end
          if (bus.pk_ready_in) begin
            void'(exp_q.pop_front());
            tag_log.push_back(bus.pk_tag_out);
          end
        end
      end

      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready_out[i]) grant_log.push_back(i);

      // Advance the model across the coming rising edge
      if (bus.ret_valid_in) begin
        r = int'(bus.ret_tag_in[ID_W-1:0]);
        if (m_out[r] == 0) m_err = 1'b1;
        else m_out[r]--;
      end
      if (g >= 0) begin
        p.data = bus.req_data_in[g*WIDTH_IN +: WIDTH_IN];
        p.dst  = bus.req_dst_in[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        p.vc   = bus.req_vc_in[g*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
        p.tag  = {m_seq[g], ID_W'(g)};
        exp_q.push_back(p);
        m_seq[g]++;
        m_out[g]++;
        m_last  = g;
        m_valid = 1'b1;
      end else if (m_valid && bus.pk_ready_in) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REQ*WIDTH_IN-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[NUM_REQ*WIDTH_IN-1:0];
  endfunction

  task automatic randomize_payloads();
    logic [31:0] t;
    t = $urandom();
    bus.req_data_in = rand_data();
    bus.req_dst_in  = t[NUM_REQ*ADDRESS_WIDTH-1:0];
    bus.req_vc_in   = t[31:32-NUM_REQ*VC_ADDRESS_WIDTH];
  endtask

  // Returns whichever word is on the packetizer port this cycle when it is being taken
  task automatic auto_return();
    bus.ret_valid_in = bus.pk_valid_out & bus.pk_ready_in;
    bus.ret_tag_in   = bus.pk_tag_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_in = '1;
    bus.pk_ready_in  = 1'b0;
    bus.ret_valid_in = 1'b0;
    bus.ret_tag_in   = '0;
    randomize_payloads();
    tick();
    tick();
    tests_run++;
    if (bus.pk_valid_out !== 1'b0 || bus.req_ready_out !== 4'b0000 || bus.err_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b err=%b expected 0/0000/0",
               bus.pk_valid_out, bus.req_ready_out, bus.err_underflow);
    end
    tests_run++;
    if ({bus.pk_data_out, bus.pk_dst_out, bus.pk_vc_out, bus.pk_tag_out} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_word: got %h/%h/%h/%h expected all zero",
               bus.pk_data_out, bus.pk_dst_out, bus.pk_vc_out, bus.pk_tag_out);
    end
    rst = 1'b0;
    bus.req_valid_in = '0;
  endtask

  task automatic test_single();
    test_reset();
    bus.req_valid_in = 4'b0100;
    bus.pk_ready_in  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_accept_c0: got %b expected 0100", bus.req_ready_out);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.pk_valid_out !== 1'b1 || bus.pk_tag_out !== 8'h02) begin
      tests_failed++;
      $display("FAIL single_tag_c1: got valid=%b tag=%h expected 1/02", bus.pk_valid_out, bus.pk_tag_out);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.pk_tag_out !== 8'h06) begin
      tests_failed++;
      $display("FAIL single_tag_second: got %h expected 06", bus.pk_tag_out);
    end
    tick();
    bus.req_valid_in = '0;
    tick();
  endtask

  task automatic test_round_robin();
    test_reset();
    grant_log.delete();
    tag_log.delete();
    bus.req_valid_in = 4'b1111;
    bus.pk_ready_in  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      randomize_payloads();
      tick();
      auto_return();
    end
    bus.req_valid_in = '0;
    tick();
    bus.ret_valid_in = 1'b0;
    tick();
    tests_run++;
    if (grant_log.size() != 16 || tag_log.size() != 16) begin
      tests_failed++;
      $display("FAIL rr_throughput: got %0d grants %0d transfers expected 16/16", grant_log.size(), tag_log.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        tests_run++;
        if (grant_log[k] != k % 4 || tag_log[k] !== 8'(k)) begin
          tests_failed++;
          $display("FAIL rr_order[%0d]: got grant %0d tag %h expected %0d/%h", k, grant_log[k], tag_log[k], k % 4, 8'(k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH_IN-1:0] d0;
    test_reset();
    bus.req_valid_in = 4'b1111;
    bus.pk_ready_in  = 1'b0;
    randomize_payloads();
    d0 = bus.req_data_in[WIDTH_IN-1:0];
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_first_grant: got %b expected 0001", bus.req_ready_out);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      randomize_payloads();
      @(negedge clk);
      tests_run++;
      if (bus.req_ready_out !== 4'b0000 || bus.pk_valid_out !== 1'b1 ||
          bus.pk_data_out !== d0 || bus.pk_tag_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b data=%h tag=%h expected 0000/1/%h/00",
                 c, bus.req_ready_out, bus.pk_valid_out, bus.pk_data_out, bus.pk_tag_out, d0);
      end
      tick();
    end
    bus.pk_ready_in = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_release_grant: got %b expected 0010", bus.req_ready_out);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.pk_valid_out !== 1'b1 || bus.pk_tag_out !== 8'h01) begin
      tests_failed++;
      $display("FAIL bp_next_word: got valid=%b tag=%h expected 1/01", bus.pk_valid_out, bus.pk_tag_out);
    end
    bus.req_valid_in = '0;
    tick();
    tick();
  endtask

  task automatic test_credit_limit();
    int n;
    test_reset();
    bus.req_valid_in = 4'b0010;
    bus.pk_ready_in  = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.req_ready_out[1] === 1'b1) n++;
      tick();
    end
    tests_run++;
    if (n != MAX_OUTSTANDING) begin
      tests_failed++;
      $display("FAIL credit_accepts: got %0d expected %0d", n, MAX_OUTSTANDING);
    end
    bus.ret_valid_in = 1'b1;
    bus.ret_tag_in   = 8'h05;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL credit_return_cycle: got %b expected 0000", bus.req_ready_out);
    end
    tick();
    bus.ret_valid_in = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tests_run++;
        if (bus.req_ready_out !== 4'b0010) begin
          tests_failed++;
          $display("FAIL credit_regrant: got %b expected 0010", bus.req_ready_out);
        end
      end
      if (bus.req_ready_out[1] === 1'b1) n++;
      tick();
    end
    tests_run++;
    if (n != 1) begin
      tests_failed++;
      $display("FAIL credit_one_more: got %0d accepts expected 1", n);
    end
    bus.req_valid_in = '0;
  endtask

  task automatic test_load_return();
    int n;
    test_reset();
    bus.req_valid_in = 4'b0001;
    bus.pk_ready_in  = 1'b1;
    tick();
    tick();
    bus.ret_valid_in = 1'b1;
    bus.ret_tag_in   = 8'h00;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL lr_simul_accept: got %b expected 0001", bus.req_ready_out);
    end
    tick();
    bus.ret_valid_in = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready_out[0] === 1'b1) n++;
      tick();
    end
    tests_run++;
    if (n != 2) begin
      tests_failed++;
      $display("FAIL lr_count_kept: got %0d further accepts expected 2", n);
    end
    bus.req_valid_in = '0;
    bus.ret_valid_in = 1'b1;
    bus.ret_tag_in   = 8'h03;
    tick();
    bus.ret_valid_in = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.err_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_set: got %b expected 1", bus.err_underflow);
    end
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.err_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow_sticky: got %b expected 1", bus.err_underflow);
    end
    tick();
  endtask

  task automatic test_seq_wrap();
    test_reset();
    tag_log.delete();
    bus.req_valid_in = 4'b0001;
    bus.pk_ready_in  = 1'b1;
    for (int c = 0; c < 100 && tag_log.size() < 65; c++) begin
      tick();
      auto_return();
    end
    bus.req_valid_in = '0;
    tick();
    bus.ret_valid_in = 1'b0;
    tick();
    tests_run++;
    if (tag_log.size() < 65) begin
      tests_failed++;
      $display("FAIL seq_wrap_timeout: got %0d transfers expected at least 65", tag_log.size());
    end else begin
      tests_run++;
      if (tag_log[1] !== 8'h04 || tag_log[63] !== 8'hFC) begin
        tests_failed++;
        $display("FAIL seq_step: got %h/%h expected 04/fc", tag_log[1], tag_log[63]);
      end
      if (tag_log[64] !== 8'h00) begin
        tests_failed++;
        $display("FAIL seq_wrap: got %h expected 00", tag_log[64]);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    bus.req_valid_in = 4'b1111;
    bus.pk_ready_in  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.pk_valid_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_holding: got %b expected 1", bus.pk_valid_out);
    end
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.pk_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_dropped: got %b expected 0", bus.pk_valid_out);
    end
    rst = 1'b0;
    bus.pk_ready_in = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.req_ready_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rm_first_grant: got %b expected 0001", bus.req_ready_out);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.pk_tag_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL rm_tag_restart: got %h expected 00", bus.pk_tag_out);
    end
    bus.req_valid_in = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_credit_limit();
    test_load_return();
    test_seq_wrap();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drained: got %0d words left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
